if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives ce/addr of the instruction ROM, captures the
//  combinational ROM word into the IF/ID pipeline register for decode. Handles sequential
//  fetch, ID-stage branch redirect, pipeline stalls, exception flush and a halt state.
//  Sits between the control/ID stages and the instruction ROM.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INST   32'h0000_0000  word inserted into IF/ID on bubble/flush
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst            in   1   asynchronous, active-low reset (0 = reset)
//  stall_if       in   1   hold PC (from stall controller)
//  stall_id       in   1   hold IF/ID register
//  branch_flag    in   1   ID resolved taken branch/jump
//  branch_target  in   32  redirect address
//  flush          in   1   exception/eret flush
//  flush_pc       in   32  handler / EPC address
//  halt_req       in   1   stop fetching after current word
//  rom_ce         out  1   ROM chip enable (CHIP_ENABLE/CHIP_DISABLE)
//  rom_addr       out  32  = pc
//  rom_inst       in   32  ROM data, combinational from rom_addr
//  id_pc          out  32  PC of word in IF/ID
//  id_inst        out  32  instruction in IF/ID
//  id_adel        out  1   word fetched from misaligned PC (AdEL)
//  halted         out  1   FSM in HALT
// BEHAVIOUR
//  Reset (async, rst=0): pc=RESET_PC, state=IDLE, rom_ce=0, id_pc=0, id_inst=NOP_INST,
//   id_adel=0, halted=0.
//  FSM: IDLE -> RUN unconditionally next edge (one cycle ce=0 after reset release).
//   RUN -> HALT on halt_req && !flush && !stall_if; HALT -> RUN only on flush.
//   rom_ce=1 in RUN only; HALT/IDLE drive CHIP_DISABLE, pc frozen.
//  PC update priority per edge (RUN): flush > stall_if > branch_flag > pc+4.
//   flush: pc<=flush_pc (also from HALT/IDLE, ignores stalls). stall_if: pc holds, branch
//   not consumed (ID keeps branch_flag asserted while stalled). pc+4 wraps FFFF_FFFC->0.
//  IF/ID update priority: flush -> bubble; stall_id -> hold; stall_if & !stall_id -> bubble;
//   state!=RUN -> bubble; else capture {pc, rom_inst, pc[1:0]!=0}.
//   Bubble = id_pc 0, id_inst NOP_INST, id_adel 0.
//  Latency: word at rom_addr in cycle n appears on id_* in cycle n+1.
//  Misaligned pc: fetched normally (ROM ignores addr[1:0]); id_adel=1 marks it; pc+4
//   keeps low bits.
//  halt_req with flush same cycle: flush wins, stays RUN. Reset mid-stall: all cleared.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs fetch_cnt[31:0] (++ each captured non-bubble word)
//   and stall_cnt[31:0] (++ each RUN cycle with stall_if=1); both reset 0, wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  const.v: InstAddrBus, InstBus, CHIP_ENABLE/DISABLE, RstEnable (=1'b0), NOP word,
//   FSM state encodings (IF_IDLE/IF_RUN/IF_HALT).
//  One sub-module: if_id_reg (IF/ID register with hold/bubble/capture control).
// TESTING
//  1 reset release, ROM word i = 0x1000_0000+i -> rom_ce 0 one cycle, then pc 0,4,8;
//    id_inst 0x1000_0000 at cycle after pc=0.
//  2 branch_flag with target 0x40 while pc=0x8 -> next pc 0x40; id_pc 0x8 then 0x40.
//  3 stall_if=stall_id=1 for 3 cycles at pc=0xC -> pc, id_pc, id_inst held; then resume 0x10.
//  4 stall_if=1, stall_id=0 one cycle -> id_inst=NOP_INST, id_pc=0; pc held.
//  5 halt_req at pc=0x14 -> halted=1, rom_ce=0; flush with flush_pc 0x180 -> RUN, pc 0x180,
//    IF/ID bubble.
//  6 flush_pc 0x182 -> id_adel=1 with id_pc 0x182; async rst low mid-run -> all outputs
//    reset immediately.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants, types and FSM encoding for the instruction-fetch stage.
// Optional performance counters in if_fetch are enabled by defining IF_PERF_CNT_EN.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam logic  CHIP_ENABLE  = 1'b1;
  localparam logic  CHIP_DISABLE = 1'b0;
  localparam logic  RST_ENABLE   = 1'b0;
  localparam inst_t NOP_WORD     = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_e;

  // The ROM ignores addr[1:0]; a non-zero low pair only flags an AdEL exception.
  function automatic logic misaligned(input inst_addr_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction ROM port plus the IF/ID register outputs toward decode.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       rom_ce;
  inst_addr_t rom_addr;
  inst_t      rom_inst;
  inst_addr_t id_pc;
  inst_t      id_inst;
  logic       id_adel;

  modport master (
    output rom_ce, rom_addr, id_pc, id_inst, id_adel,
    input  rom_inst
  );

  modport slave (
    input  rom_ce, rom_addr, id_pc, id_inst, id_adel,
    output rom_inst
  );

endinterface

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register: flush/stall-driven bubble, hold on ID stall, capture otherwise.
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter inst_t NOP_INST = NOP_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stall_if,
  input  logic       stall_id,
  input  logic       run,
  input  inst_addr_t pc,
  input  inst_t      inst,
  output inst_addr_t id_pc,
  output inst_t      id_inst,
  output logic       id_adel,
  output logic       capture
);

  logic bubble;

  // A stalled IF with a free ID must not hand decode the same word twice.
  assign bubble  = flush || (!stall_id && (stall_if || !run));
  assign capture = !flush && !stall_id && !stall_if && run;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset branch must be the first test.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      id_pc   <= '0;
      id_inst <= NOP_INST;
      id_adel <= 1'b0;
    end else if (bubble) begin
      id_pc   <= '0;
      id_inst <= NOP_INST;
      id_adel <= 1'b0;
    end else if (capture) begin
      id_pc   <= pc;
      id_inst <= inst;
      id_adel <= misaligned(pc);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC/FSM ownership, ROM drive and IF/ID capture.
// Define IF_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter inst_t      NOP_INST = NOP_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_if,
  input  logic       stall_id,
  input  logic       branch_flag,
  input  inst_addr_t branch_target,
  input  logic       flush,
  input  inst_addr_t flush_pc,
  input  logic       halt_req,
  if_fetch_if.master bus,
  output logic       halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  if_state_e  state;
  inst_addr_t pc;
  logic       rom_ce_q;
  logic       capture;

  assign bus.rom_ce   = rom_ce_q;
  assign bus.rom_addr = pc;

  // Flush redirects from any state and overrides both stall and halt.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state    <= IF_IDLE;
      pc       <= RESET_PC;
      rom_ce_q <= CHIP_DISABLE;
      halted   <= 1'b0;
    end else if (flush) begin
      state    <= IF_RUN;
      pc       <= flush_pc;
      rom_ce_q <= CHIP_ENABLE;
      halted   <= 1'b0;
    end else begin
      case (state)
        IF_IDLE: begin
          state    <= IF_RUN;
          rom_ce_q <= CHIP_ENABLE;
        end
        IF_RUN: begin
          if (!stall_if) begin
            pc <= branch_flag ? branch_target : pc + 32'd4;
            if (halt_req) begin
              state    <= IF_HALT;
              rom_ce_q <= CHIP_DISABLE;
              halted   <= 1'b1;
            end
          end
        end
        IF_HALT: ;
        default: begin
          state    <= IF_IDLE;
          rom_ce_q <= CHIP_DISABLE;
          halted   <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_if (stall_if),
    .stall_id (stall_id),
    .run      (state == IF_RUN),
    .pc       (pc),
    .inst     (bus.rom_inst),
    .id_pc    (bus.id_pc),
    .id_inst  (bus.id_inst),
    .id_adel  (bus.id_adel),
    .capture  (capture)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (capture)                      fetch_cnt <= fetch_cnt + 32'd1;
      if (state == IF_RUN && stall_if)  stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed scenarios then random traffic against a PC/IF-ID model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;
  localparam int          MODE_IDLE  = 0;
  localparam int          MODE_RUN   = 1;
  localparam int          MODE_HALT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0, stall_id = 1'b0, branch_flag = 1'b0;
  logic        flush = 1'b0, halt_req = 1'b0;
  logic [31:0] branch_target = '0, flush_pc = '0;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  if_fetch_if bus ();

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.rom_inst = rom_word(bus.rom_addr);

  if_fetch #(
    .RESET_PC (T_RESET_PC),
    .NOP_INST (T_NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .halt_req      (halt_req),
    .bus           (bus),
    .halted        (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        adel;
    logic        halted;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int          m_mode;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_fcnt, m_scnt;
  logic        m_adel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_IDLE; m_pc = T_RESET_PC;
    m_id_pc = '0; m_id_inst = T_NOP; m_adel = 1'b0;
    m_fcnt = '0; m_scnt = '0;
  endtask

  task automatic model_edge(input bit sif, sid, br, input logic [31:0] tgt,
                            input bit fl, input logic [31:0] fpc, input bit hr);
    if (m_mode == MODE_RUN && sif) m_scnt++;
    if (fl || (!sid && (sif || m_mode != MODE_RUN))) begin
      m_id_pc = '0; m_id_inst = T_NOP; m_adel = 1'b0;
    end else if (!sid) begin
      m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_adel = (m_pc % 4) != 0;
      m_fcnt++;
    end
    if (fl) begin
      m_pc = fpc; m_mode = MODE_RUN;
    end else if (m_mode == MODE_IDLE) begin
      m_mode = MODE_RUN;
    end else if (m_mode == MODE_RUN && !sif) begin
      m_pc = br ? tgt : m_pc + 4;
      if (hr) m_mode = MODE_HALT;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.ce = (m_mode == MODE_RUN); e.addr = m_pc; e.id_pc = m_id_pc;
    e.id_inst = m_id_inst; e.adel = m_adel; e.halted = (m_mode == MODE_HALT);
    e.fcnt = m_fcnt; e.scnt = m_scnt;
    sb.push_back(e);
  endtask

  // One clock of stimulus: drives inputs between edges and records what the next edge must yield.
  task automatic step(input bit r, sif, sid, br, input logic [31:0] tgt,
                      input bit fl, input logic [31:0] fpc, input bit hr);
    @(negedge clk); #1;
    stall_if = sif; stall_id = sid; branch_flag = br; branch_target = tgt;
    flush = fl; flush_pc = fpc; halt_req = hr;
    if (!r && rst) begin
      rst = 1'b0; #1;
      check("async_rst_ce",      bus.rom_ce,   1'b0);
      check("async_rst_addr",    bus.rom_addr, T_RESET_PC);
      check("async_rst_id_pc",   bus.id_pc,    32'h0);
      check("async_rst_id_inst", bus.id_inst,  T_NOP);
      check("async_rst_adel",    bus.id_adel,  1'b0);
      check("async_rst_halted",  halted,       1'b0);
    end else begin
      rst = r;
    end
    if (!r) model_reset();
    else    model_edge(sif, sid, br, tgt, fl, fpc, hr);
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic do_flush(input logic [31:0] fpc);
    step(1, 0, 0, 0, '0, 1, fpc, 0);
  endtask

  // Monitor: compares DUT outputs on the falling edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rom_ce",   bus.rom_ce,   e.ce);
        check("rom_addr", bus.rom_addr, e.addr);
        check("id_pc",    bus.id_pc,    e.id_pc);
        check("id_inst",  bus.id_inst,  e.id_inst);
        check("id_adel",  bus.id_adel,  e.adel);
        check("halted",   halted,       e.halted);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, e.fcnt);
        check("stall_cnt", stall_cnt, e.scnt);
`endif
      end
    end
  end

  initial begin
    int w;
    model_reset();
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, '0, 0, '0, 0);

    // Reset release, sequential fetch, then branch from pc=0x8 to 0x40
    idle(3);
    step(1, 0, 0, 1, 32'h40, 0, '0, 0);
    idle(2);

    // Joint stall at pc=0xC, then a lone IF stall producing a bubble
    do_flush(32'hC);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, '0, 0, '0, 0);
    idle(2);
    step(1, 1, 0, 0, '0, 0, '0, 0);
    idle(1);

    // Halt at pc=0x14, flush back to 0x180
    do_flush(32'h14);
    step(1, 0, 0, 0, '0, 0, '0, 1);
    idle(3);
    do_flush(32'h180);
    idle(2);

    // Halt blocked by flush or by stall in the same cycle
    step(1, 0, 0, 0, '0, 1, 32'h200, 1);
    step(1, 1, 0, 0, '0, 0, '0, 1);
    idle(1);

    // Misaligned fetch, PC wrap, branch held through stall
    do_flush(32'h182);
    idle(2);
    do_flush(32'hFFFF_FFF8);
    idle(3);
    step(1, 1, 0, 1, 32'h300, 0, '0, 0);
    step(1, 0, 0, 1, 32'h300, 0, '0, 0);
    idle(1);

    // Async reset in the middle of a stall, then recovery
    step(1, 1, 1, 0, '0, 0, '0, 0);
    step(0, 1, 1, 0, '0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0, '0, 0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt, fpc;
      tgt = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
      fpc = ($urandom % 4 == 0) ? ($urandom & 32'h0000_0FFF) : ($urandom & 32'h0000_0FFC);
      step(($urandom % 400) != 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
           ($urandom % 5) == 0, tgt, ($urandom % 20) == 0, fpc, ($urandom % 25) == 0);
    end

    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
